// File: rtl/alu_pkg.sv
// alu_pkg: opcode/funct3 encodings and the internal ALU operation set shared by decode and execute.
package alu_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW
    } alu_op_e;

    function automatic alu_op_e base_op(input logic [2:0] f3, input logic sub, input logic sra);
        case (f3)
            F3_ADD:  base_op = sub ? ALU_SUB : ALU_ADD;
            F3_SLL:  base_op = ALU_SLL;
            F3_SLT:  base_op = ALU_SLT;
            F3_SLTU: base_op = ALU_SLTU;
            F3_XOR:  base_op = ALU_XOR;
            F3_SR:   base_op = sra ? ALU_SRA : ALU_SRL;
            F3_OR:   base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e word_op(input alu_op_e op);
        case (op)
            ALU_SUB: word_op = ALU_SUBW;
            ALU_SLL: word_op = ALU_SLLW;
            ALU_SRL: word_op = ALU_SRLW;
            ALU_SRA: word_op = ALU_SRAW;
            default: word_op = ALU_ADDW;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode: maps {opcode, funct3, funct7} to an ALU op, word flag and illegal flag.
// RV64 word opcodes decode only when ALU_WORD_OPS_EN is defined; otherwise they are illegal.
module alu_decode
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_func3,
    input  logic [6:0] i_func7,
    output alu_op_e    o_op,
    output logic       o_word,
    output logic       o_illegal
);

    always_comb begin
        o_op = base_op(i_func3, 1'b0, i_func7[5]);
        o_word = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_IMM: ;
            OP: begin
                o_op = base_op(i_func3, i_func7[5], i_func7[5]);
                o_illegal = !(i_func7 == 7'b0 || (i_func7 == F7_ALT && (i_func3 == F3_ADD || i_func3 == F3_SR)));
            end
            LOAD, STORE: o_op = ALU_ADD;
`ifdef ALU_WORD_OPS_EN
            OP_IMM_32: begin
                o_op = word_op(base_op(i_func3, 1'b0, i_func7[5]));
                o_word = 1'b1;
                o_illegal = !(i_func3 inside {F3_ADD, F3_SLL, F3_SR});
            end
            OP_32: begin
                o_op = word_op(base_op(i_func3, i_func7[5], i_func7[5]));
                o_word = 1'b1;
                o_illegal = !(i_func3 inside {F3_ADD, F3_SLL, F3_SR}) ||
                            !(i_func7 == 7'b0 || (i_func7 == F7_ALT && i_func3 != F3_SLL));
            end
`endif
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready integer ALU (S1 = decoded op + operands, S2 = result + illegal).
// Word ops come from alu_decode under ALU_WORD_OPS_EN and are rejected here unless XLEN is 64.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            illegal
);

    localparam int SW = $clog2(XLEN);

    alu_op_e   w_dec_op;
    logic      w_dec_word;
    logic      w_dec_illegal;
    alu_op_e   r_op;
    logic      r_word;
    logic      r_ill;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic      r_s1_valid;
    logic      r_s2_valid;
    logic [XLEN-1:0] r_out;
    logic      r_illegal;
    logic      w_s2_adv;
    logic      w_s1_adv;
    logic      w_in_fire;
    logic [SW-1:0]   w_sh;
    logic [4:0]      w_sh32;
    logic [XLEN-1:0] w_full;
    logic [31:0]     w_w32;
    logic signed [XLEN-1:0] w_sext;
    logic [XLEN-1:0] w_res;

    alu_decode u_decode (
        .i_opcode (opcode),
        .i_func3  (func3),
        .i_func7  (func7),
        .o_op     (w_dec_op),
        .o_word   (w_dec_word),
        .o_illegal(w_dec_illegal)
    );

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_adv;
    assign in_ready  = !rst && (!r_s1_valid || w_s1_adv);
    assign w_in_fire = in_valid && in_ready;
    assign out_valid = r_s2_valid;
    assign out       = r_out;
    assign illegal   = r_illegal;

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_op   <= w_dec_op;
            r_word <= w_dec_word;
            r_ill  <= w_dec_illegal || (w_dec_word && XLEN != 64);
            r_a    <= a;
            r_b    <= b;
        end
    end

    assign w_sh   = r_b[SW-1:0];
    assign w_sh32 = r_b[4:0];

    always_comb begin
        w_full = '0;
        w_w32 = '0;
        case (r_op)
            ALU_ADD:  w_full = r_a + r_b;
            ALU_SUB:  w_full = r_a - r_b;
            ALU_SLL:  w_full = r_a << w_sh;
            ALU_SLT:  w_full = XLEN'($signed(r_a) < $signed(r_b));
            ALU_SLTU: w_full = XLEN'(r_a < r_b);
            ALU_XOR:  w_full = r_a ^ r_b;
            ALU_SRL:  w_full = r_a >> w_sh;
            ALU_SRA:  w_full = $signed(r_a) >>> w_sh;
            ALU_OR:   w_full = r_a | r_b;
            ALU_AND:  w_full = r_a & r_b;
            ALU_ADDW: w_w32 = r_a[31:0] + r_b[31:0];
            ALU_SUBW: w_w32 = r_a[31:0] - r_b[31:0];
            ALU_SLLW: w_w32 = r_a[31:0] << w_sh32;
            ALU_SRLW: w_w32 = r_a[31:0] >> w_sh32;
            ALU_SRAW: w_w32 = $signed(r_a[31:0]) >>> w_sh32;
            default:  w_full = '0;
        endcase
        w_sext = $signed(w_w32);
        w_res = r_ill ? '0 : r_word ? w_sext : w_full;
    end

    // S2 reloads whenever S1 hands over, so an output transfer and a refill share one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_out      <= '0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_in_fire) r_s1_valid <= 1'b1;
            else if (w_s1_adv) r_s1_valid <= 1'b0;
            if (w_s2_adv) r_s2_valid <= r_s1_valid;
            if (w_s1_adv) begin
                r_out     <= w_res;
                r_illegal <= r_ill;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (XLEN=64); word-op expectations follow ALU_WORD_OPS_EN.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;
    logic        illegal;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] a;
        logic [63:0] b;
    } req_t;

    typedef struct packed {
        logic        ill;
        logic [63:0] out;
    } exp_t;

    req_t pend[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    bit   rand_bp = 1'b0;

    always #5 clk = ~clk;

    alu_pipe #(.XLEN(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .func3    (func3),
        .func7    (func7),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .illegal  (illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input req_t r);
        exp_t e;
        logic [31:0] w;
        logic [31:0] sra32;
        logic alt;
        logic sub;
        e = '0;
        w = '0;
        alt = r.f7[5];
        sra32 = $signed(r.a[31:0]) >>> r.b[4:0];
        sub = r.op == 7'h3B && alt;
        case (r.op)
            7'h03, 7'h23: e.out = r.a + r.b;
            7'h13, 7'h33: begin
                if (r.op == 7'h33 && !(r.f7 == 7'h00 || (r.f7 == 7'h20 && (r.f3 == 3'd0 || r.f3 == 3'd5))))
                    e.ill = 1'b1;
                else case (r.f3)
                    3'd0: e.out = (r.op == 7'h33 && alt) ? r.a - r.b : r.a + r.b;
                    3'd1: e.out = r.a << r.b[5:0];
                    3'd2: e.out = {63'b0, $signed(r.a) < $signed(r.b)};
                    3'd3: e.out = {63'b0, r.a < r.b};
                    3'd4: e.out = r.a ^ r.b;
                    3'd5: if (alt) e.out = $signed(r.a) >>> r.b[5:0]; else e.out = r.a >> r.b[5:0];
                    3'd6: e.out = r.a | r.b;
                    default: e.out = r.a & r.b;
                endcase
            end
`ifdef ALU_WORD_OPS_EN
            7'h1B, 7'h3B: begin
                if (r.f3 != 3'd0 && r.f3 != 3'd1 && r.f3 != 3'd5) e.ill = 1'b1;
                if (r.op == 7'h3B && !(r.f7 == 7'h00 || (r.f7 == 7'h20 && r.f3 != 3'd1))) e.ill = 1'b1;
                if (r.f3 == 3'd0) w = sub ? r.a[31:0] - r.b[31:0] : r.a[31:0] + r.b[31:0];
                else if (r.f3 == 3'd1) w = r.a[31:0] << r.b[4:0];
                else w = alt ? sra32 : r.a[31:0] >> r.b[4:0];
                if (!e.ill) e.out = {{32{w[31]}}, w};
            end
`endif
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) check("stale_out", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                check("out", out, e.out);
                check("illegal", {63'b0, illegal}, {63'b0, e.ill});
            end
        end
    end

    task automatic step();
        bit acc;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        if (pend.size() != 0) begin
            in_valid = 1'b1;
            {opcode, func3, func7, a, b} = pend[0];
        end else begin
            in_valid = 1'b0;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
        end
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            sb.push_back(model(pend[0]));
            void'(pend.pop_front());
            n_acc++;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((pend.size() != 0 || sb.size() != 0) && k < 2000) begin
            step();
            k++;
        end
        check("drain_left", 64'(pend.size() + sb.size()), 64'd0);
    endtask

    task automatic one(input string tag, input req_t r, input logic [63:0] exp, input logic ill);
        int k = 0;
        pend.push_back(r);
        while (pend.size() != 0 && k < 20) begin
            step();
            k++;
        end
        k = 0;
        while (!out_valid && k < 10) begin
            step();
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'd1);
        check(tag, out, exp);
        check({tag, "_ill"}, {63'b0, illegal}, {63'b0, ill});
    endtask

    initial begin
        logic [63:0] held;
        logic [6:0] ops [8];
        ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h1B, 7'h3B, 7'h7F, 7'h00};
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        opcode = '0;
        func3 = '0;
        func7 = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out", out, 64'd0);
        check("rst_illegal", {63'b0, illegal}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {63'b0, in_ready}, 64'd1);

        one("sub", '{7'h33, 3'd0, 7'h20, 64'd5, 64'd7}, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        one("sra", '{7'h13, 3'd5, 7'h20, 64'h8000_0000_0000_0000, 64'd4}, 64'hF800_0000_0000_0000, 1'b0);
        one("srl", '{7'h13, 3'd5, 7'h00, 64'h8000_0000_0000_0000, 64'd4}, 64'h0800_0000_0000_0000, 1'b0);
        one("slt", '{7'h33, 3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1}, 64'd1, 1'b0);
        one("sltu", '{7'h33, 3'd3, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1}, 64'd0, 1'b0);
        one("bad_op", '{7'h7F, 3'd0, 7'h00, 64'd9, 64'd3}, 64'd0, 1'b1);
        one("bad_f7", '{7'h33, 3'd1, 7'h20, 64'd9, 64'd3}, 64'd0, 1'b1);
        one("store_ea", '{7'h23, 3'd3, 7'h00, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8}, 64'hFF8, 1'b0);
`ifdef ALU_WORD_OPS_EN
        one("addw", '{7'h3B, 3'd0, 7'h00, 64'h7FFF_FFFF, 64'd1}, 64'hFFFF_FFFF_8000_0000, 1'b0);
`else
        one("addw", '{7'h3B, 3'd0, 7'h00, 64'h7FFF_FFFF, 64'd1}, 64'd0, 1'b1);
`endif
        drain();

        out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 4; i++)
            pend.push_back('{7'h13, 3'd0, 7'h00, 64'(100 * (i + 1)), 64'(i + 1)});
        repeat (5) step();
        check("bp_accepts", 64'(n_acc), 64'd2);
        check("bp_in_ready", {63'b0, in_ready}, 64'd0);
        check("bp_out_valid", {63'b0, out_valid}, 64'd1);
        held = out;
        check("bp_head", held, 64'd101);
        step();
        check("bp_stable", out, held);
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        n_acc = 0;
        pend.push_back('{7'h13, 3'd4, 7'h00, 64'hF0, 64'h0F});
        pend.push_back('{7'h33, 3'd6, 7'h00, 64'h3, 64'h4});
        step();
        step();
        check("rst_inflight", 64'(n_acc), 64'd2);
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("midrst_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_out", out, 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("post_rst_valid", {63'b0, out_valid}, 64'd0);

        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            req_t r;
            r.op = ops[$urandom_range(0, 7)];
            if (r.op == 7'h00) r.op = 7'($urandom);
            r.f3 = 3'($urandom);
            r.f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ($urandom_range(0, 1) != 0 ? 7'h20 : 7'h00);
            r.a = {$urandom, $urandom};
            r.b = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
            pend.push_back(r);
        end
        drain();
        rand_bp = 1'b0;
        out_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
